fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline, sitting directly upstream of the fetch/decode latch. It owns the program counter, issues instruction-memory requests, and applies control-transfer redirects resolved in the memory stage. It produces the fetch-side latch inputs `instr_fet` and `pc4_fet`, plus a valid qualifier. It also absorbs the corner case where a redirect arrives while an instruction fetch is still outstanding.

## Interface
- `PC_INIT`, default 32'h0000_0000: PC value loaded on reset.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `iREN`  out  1  instruction-memory read request.
- `iaddr`  out  32  instruction-memory address.
- `ihit`  in  1  instruction-memory data valid this cycle.
- `iload`  in  32  instruction word returned by memory.
- `redirect`  in  1  taken control transfer resolved in the memory stage this cycle.
- `PCSrc_mem`  in  2  target select: 0 = none, 1 = `baddr_mem`, 2 = `jaddr_mem`, 3 = `rdat1_mem` (JR).
- `baddr_mem`, `jaddr_mem`, `rdat1_mem`  in  32 each  candidate redirect targets.
- `stall`  in  1  fetch/decode latch is holding this cycle; PC must not advance.
- `halt`  in  1  halt instruction has reached writeback.
- `instr_fet`  out  32  fetched instruction; 0 when `fet_valid` = 0.
- `pc4_fet`  out  32  PC+4 of the fetched instruction.
- `fet_valid`  out  1  `instr_fet` is a real instruction for the latch to capture.

## Operation
- State register `st` has three states: FETCH, DRAIN and HALTED. Other registers are `pc` (32 bits) and `tgt_q` (32 bits).
- A redirect is effective only when `redirect` = 1 and `PCSrc_mem` != 0. With `PCSrc_mem` = 0, `redirect` is ignored.
- The effective target `tgt` is the source selected by `PCSrc_mem`, with bits [1:0] forced to 00.
- `pc4_fet` = `pc` + 4, computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- FETCH state:
  - Outputs: `iREN` = 1, `iaddr` = `pc`.
  - Effective redirect and `ihit` = 1: `pc` <= `tgt`, `fet_valid` = 0 (the wrong-path word is discarded). Stay in FETCH.
  - Effective redirect and `ihit` = 0: `tgt_q` <= `tgt`, go to DRAIN, `fet_valid` = 0. `pc` is unchanged.
  - No redirect and `ihit` = 1: `fet_valid` = 1, `instr_fet` = `iload`. `pc` <= `pc` + 4 only if `stall` = 0. Under stall, the same address is re-presented next cycle.
  - No redirect and `ihit` = 0: hold everything, `fet_valid` = 0.
- DRAIN state (a request is already in flight to memory and its address must not change mid-miss):
  - Outputs: `iREN` = 1, `iaddr` = `pc` (the old address), `fet_valid` = 0 always.
  - A further effective redirect overwrites `tgt_q` with the new `tgt`. Newest wins.
  - When `ihit` = 1: `pc` <= `tgt_q` (or `tgt`, if a redirect is effective that same cycle), then go to FETCH.
- HALTED state:
  - Outputs: `iREN` = 0, `fet_valid` = 0; `iaddr` = `pc` (frozen).
  - Exits only on `RST`.
- `halt` = 1 in any state moves to HALTED on the next edge.
  - `halt` has priority over redirect and `ihit`.
  - It takes effect even in DRAIN; an outstanding request is abandoned.
- `stall` never blocks redirects or DRAIN completion. Flushing of the latch is the hazard unit's job.

## Timing
- On reset assertion (asynchronous): `st` = FETCH, `pc` = `PC_INIT`, `tgt_q` = 0.
  - Resulting outputs: `iREN` = 1, `iaddr` = `PC_INIT`, `pc4_fet` = `PC_INIT` + 4.
  - `fet_valid` = 0 and `instr_fet` = 0 unless `ihit` = 1.
- `instr_fet`, `fet_valid`, `iREN`, `iaddr` and `pc4_fet` are combinational from `st`, `pc`, `ihit`, `iload`, `redirect`, `PCSrc_mem` and `halt`.
  - There are no registered outputs, so fetch-to-latch latency is zero cycles.
  - `halt` gates nothing combinationally in the current cycle. It only changes state at the next edge.
- A redirect taken in FETCH with a hit puts the new target on `iaddr` in the next cycle (one cycle of bubble).
- A redirect taken on a miss puts the new target on `iaddr` in the cycle after the old request's `ihit`.
- Reset asserted mid-DRAIN drops `tgt_q`; fetch restarts at `PC_INIT`.

## Test plan
- Reset, then `ihit` = 1 every cycle, `iload` = 32'h2001_0005, no stall: `iaddr` steps 0, 4, 8, 12; `fet_valid` = 1 each cycle; `pc4_fet` = 4, 8, 12, 16.
- With `pc` = 8, hold `stall` = 1 for 3 cycles with `ihit` = 1: `iaddr` stays 8 for all 3 cycles, `fet_valid` = 1, then advances to 12 after `stall` drops.
- At `pc` = 16 with `ihit` = 1, assert `redirect`, `PCSrc_mem` = 1, `baddr_mem` = 32'h40: `fet_valid` = 0 that cycle; next cycle `iaddr` = 32'h40.
- At `pc` = 20 with `ihit` = 0, assert a redirect to `jaddr_mem` = 32'h100, then one cycle later a redirect to `rdat1_mem` = 32'h203:
  - `iaddr` holds 20 until `ihit`, with `fet_valid` = 0 on the hit.
  - Next cycle `iaddr` = 32'h200 (newest target, low bits cleared).
- `redirect` = 1 with `PCSrc_mem` = 0 at `pc` = 32 with a hit: ignored; `fet_valid` = 1 and the next `iaddr` is 36.
- Wrap and halt together: reset with `PC_INIT` = 32'hFFFF_FFFC, `ihit` = 1: `pc4_fet` = 0 and the next `iaddr` = 0. Then assert `halt`: `iREN` = 0 from the next cycle on, and it stays 0 until `RST`.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem reads, and applies memory-stage
// redirects, deferring a redirect that lands during an outstanding miss until it completes.
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        ihit,
   input  logic [31:0] iload,
   input  logic        redirect,
   input  logic [1:0]  PCSrc_mem,
   input  logic [31:0] baddr_mem,
   input  logic [31:0] jaddr_mem,
   input  logic [31:0] rdat1_mem,
   input  logic        stall,
   input  logic        halt,
   output logic [31:0] instr_fet,
   output logic [31:0] pc4_fet,
   output logic        fet_valid
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } st_t;

   st_t         st_q, st_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        redir_s;
   logic [31:0] tgt_sel_s;
   logic [31:0] tgt_s;

   // Redirect target selection and combinational fetch outputs
   always_comb begin
      redir_s = redirect && (PCSrc_mem != 2'b00);
      case (PCSrc_mem)
         2'd1:    tgt_sel_s = baddr_mem;
         2'd2:    tgt_sel_s = jaddr_mem;
         2'd3:    tgt_sel_s = rdat1_mem;
         default: tgt_sel_s = 32'h0000_0000;
      endcase
      tgt_s = tgt_sel_s & 32'hFFFF_FFFC;

      iREN      = (st_q != HALTED);
      iaddr     = pc_q;
      pc4_fet   = pc_q + 32'd4;
      fet_valid = (st_q == FETCH) && ihit && !redir_s;
      if (fet_valid) begin
         instr_fet = iload;
      end else begin
         instr_fet = 32'h0000_0000;
      end
   end

   // Next-state logic; halt outranks redirect and hit in every state
   always_comb begin
      st_d  = st_q;
      pc_d  = pc_q;
      tgt_d = tgt_q;
      if (halt) begin
         st_d = HALTED;
      end else begin
         case (st_q)
            FETCH: begin
               if (redir_s && ihit) begin
                  pc_d = tgt_s;
               end else if (redir_s) begin
                  tgt_d = tgt_s;
                  st_d  = DRAIN;
               end else if (ihit && !stall) begin
                  pc_d = pc_q + 32'd4;
               end else begin
                  pc_d = pc_q;
               end
            end
            DRAIN: begin
               // The in-flight address stays on iaddr until memory answers
               if (redir_s) begin
                  tgt_d = tgt_s;
               end else begin
                  tgt_d = tgt_q;
               end
               if (ihit) begin
                  pc_d = redir_s ? tgt_s : tgt_q;
                  st_d = FETCH;
               end else begin
                  st_d = DRAIN;
               end
            end
            HALTED: begin
               st_d = HALTED;
            end
            default: begin
               st_d = FETCH;
            end
         endcase
      end
   end

   // State registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st_q  <= FETCH;
         pc_q  <= PC_INIT;
         tgt_q <= 32'h0000_0000;
      end else begin
         st_q  <= st_d;
         pc_q  <= pc_d;
         tgt_q <= tgt_d;
      end
   end

endmodule
